datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 32-bit single-bus CPU datapath, controlled externally cycle by cycle; the control unit or testbench drives every enable/out strobe.
- Contains:
  - R0–R15, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z, InPort, OutPort and the CON flip-flop.
  - Select/encode logic for IR register fields.
  - 32-bit bus multiplexer.
  - ALU decoding IR[31:27].
- Memory is external; data enters via Mdatain.

Parameters:
- none

Ports:
- Clock  in  1  system clock; all registers update on rising edge
- Clear  in  1  asynchronous active-high reset
- OutPort_output  out  32  contents of OutPort register
- IncPC  in  1  with PC_enable: PC<=PC+1
- CONin  in  1  load CON flip-flop
- RAM_write  in  1  reserved; no internal effect
- MDR_enable  in  1  load MDR
- MDRout  in  1  MDR drives bus
- MAR_enable  in  1  load MAR from bus
- IR_enable  in  1  load IR from bus
- MDR_read  in  1  MDR source: 1=Mdatain, 0=bus
- Gra/Grb/Grc  in  1 each  select IR Ra[26:23] / Rb[22:19] / Rc[18:15]
- HI_enable, LO_enable  in  1  load HI/LO from bus
- ZHighIn, ZLowIn  in  1  load Z[63:32] / Z[31:0] from ALU result
- Y_enable  in  1  load Y from bus
- PC_enable  in  1  load/increment PC
- OutPort_enable  in  1  load OutPort from bus
- InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout  in  1  drive bus from the named source; Cout drives sign-extended IR[18:0]
- BAout  in  1  selected register drives bus; R0 reads as 0
- InPort_input  in  32  external input; sampled into InPort every clock
- Mdatain  in  32  memory read data
- R_in  in  1  load selected register from bus
- R_out  in  1  selected register drives bus
- Cin  in  1  reserved; ignored

Behaviour:
- Clear=1 resets every register, including PC, IR, Z, CON and OutPort, to 0 immediately; OutPort_output=0. A clear asserted mid-operation discards all state.
- Register select:
  - Register index = OR of (Gra&Ra, Grb&Rb, Grc&Rc); none selected gives R0.
  - R_in writes the selected register; R0 is writable.
  - R_out reads the selected register's true value.
  - BAout reads the selected register, except R0 reads 0.
- Bus source priority, highest first: R_out, BAout, HIout, LOout, ZHighout, ZLowout, PCout, MDRout, InPortout, Cout, Yout. No strobe asserted: bus=0.
- PC:
  - PC_enable&IncPC: PC<=PC+1.
  - PC_enable alone: PC<=bus.
- MDR: MDR_enable loads Mdatain if MDR_read=1, else the bus value.
- ALU:
  - Combinational; A=Y, B=bus, opcode=IR[31:27]; produces 64-bit result.
  - Result is [31:0] unless noted; [63:32]=0 unless noted.
  - Opcodes:
    - 00011 add, 00100 sub, 01011 addi
    - 01001 and, 01100 andi, 01010 or, 01101 ori
    - 00101 shr (logical), 00110 shl, 00111 ror, 01000 rol; shift amount = B[4:0]
    - 01110 mul: signed 64-bit product, all bits
    - 01111 div: signed; [31:0]=quotient, [63:32]=remainder; divide by 0 gives 0
    - 10000 neg, 10001 not (operate on B)
    - other opcodes: A+B (used for PC/address arithmetic)
  - Add/sub wrap modulo 2^32.
- CON: on CONin, CON<= condition IR[20:19] tested on bus: 00 zero, 01 nonzero, 10 positive (≥0 and ≠0), 11 negative.
- All loads take effect at the rising edge when the enable is high; bus and ALU are combinational, so read→load has zero-cycle latency.
- Simultaneous writes to different registers in one cycle are legal.

Test Plan:
- Reset: Clear pulse mid-run -> OutPort_output=0; PC=0, IR=0.
- PC increment: IncPC=PC_enable=1 for one edge from reset -> PC=1. Then PCout+MAR_enable -> MAR=1.
- Fetch:
  - Mdatain=0x59080002, MDR_read=MDR_enable=1 -> MDR=0x59080002.
  - Then MDRout+IR_enable -> IR=0x59080002.
- addi r2,r1,2:
  - Preload R1=5.
  - Grb+R_out+Y_enable -> Y=5.
  - Cout+ZLowIn -> Z[31:0]=7.
  - ZLowout+Gra+R_in -> R2=7.
  - Gra+R_out+OutPort_enable -> OutPort_output=7.
- mflo: LO loaded with 0x00001234 via MDR. Then Gra+R_in+LOout (IR Ra=2) -> R2=0x00001234; read back on OutPort.
- mul/div:
  - IR opcode 01110, Y=-3, bus=4 -> Z=0xFFFFFFFF_FFFFFFF4.
  - opcode 01111, Y=17, bus=5 -> Z high=2, low=3.
  - BAout with Ra=0 (R0=9) -> bus 0.

Source files
------------

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Every load and bus drive comes from an external control unit, one cycle at a time.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  output logic [31:0] OutPort_output,
  input  logic        IncPC,
  input  logic        CONin,
  input  logic        RAM_write,
  input  logic        MDR_enable,
  input  logic        MDRout,
  input  logic        MAR_enable,
  input  logic        IR_enable,
  input  logic        MDR_read,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        HI_enable,
  input  logic        LO_enable,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Y_enable,
  input  logic        PC_enable,
  input  logic        OutPort_enable,
  input  logic        InPortout,
  input  logic        PCout,
  input  logic        Yout,
  input  logic        ZLowout,
  input  logic        ZHighout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        Cout,
  input  logic        BAout,
  input  logic [31:0] InPort_input,
  input  logic [31:0] Mdatain,
  input  logic        R_in,
  input  logic        R_out,
  input  logic        Cin
);

  logic [31:0] regs [16];
  logic [31:0] pc, ir, mar, mdr, hi, lo, y, inport, outport;
  logic [63:0] z;
  logic        con;

  logic [31:0] bus;
  logic [63:0] alu_result;
  logic [3:0]  sel;
  logic [31:0] c_sext;
  logic        con_next;
  logic [4:0]  op;
  logic [4:0]  sh;
  logic [63:0] rot_r, rot_l, prod;
  logic [31:0] quo, rem;

  // MAR and CON have no consumer inside this block; RAM_write and Cin are reserved.
  logic unused_ok;
  assign unused_ok = ^{RAM_write, Cin, mar, con};

  assign sel    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_sext = {{13{ir[18]}}, ir[18:0]};
  assign OutPort_output = outport;

  always_comb begin
    bus = '0;
    if (R_out)          bus = regs[sel];
    else if (BAout)     bus = (sel == 4'd0) ? '0 : regs[sel];
    else if (HIout)     bus = hi;
    else if (LOout)     bus = lo;
    else if (ZHighout)  bus = z[63:32];
    else if (ZLowout)   bus = z[31:0];
    else if (PCout)     bus = pc;
    else if (MDRout)    bus = mdr;
    else if (InPortout) bus = inport;
    else if (Cout)      bus = c_sext;
    else if (Yout)      bus = y;
  end

  assign op    = ir[31:27];
  assign sh    = bus[4:0];
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;
  assign prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
  assign quo   = $signed(y) / $signed(bus);
  assign rem   = $signed(y) % $signed(bus);

  always_comb begin
    alu_result = '0;
    case (op)
      5'b00100:           alu_result[31:0] = y - bus;
      5'b01001, 5'b01100: alu_result[31:0] = y & bus;
      5'b01010, 5'b01101: alu_result[31:0] = y | bus;
      5'b00101:           alu_result[31:0] = y >> sh;
      5'b00110:           alu_result[31:0] = y << sh;
      5'b00111:           alu_result[31:0] = rot_r[31:0];
      5'b01000:           alu_result[31:0] = rot_l[63:32];
      5'b01110:           alu_result = prod;
      5'b01111:           if (bus != '0) alu_result = {rem, quo};
      5'b10000:           alu_result[31:0] = -bus;
      5'b10001:           alu_result[31:0] = ~bus;
      // add, addi and every unassigned opcode share the plain adder
      default:            alu_result[31:0] = y + bus;
    endcase
  end

  always_comb begin
    case (ir[20:19])
      2'b00:   con_next = (bus == '0);
      2'b01:   con_next = (bus != '0);
      2'b10:   con_next = !bus[31] && (bus != '0);
      default: con_next = bus[31];
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pc      <= '0;
      ir      <= '0;
      mar     <= '0;
      mdr     <= '0;
      hi      <= '0;
      lo      <= '0;
      y       <= '0;
      z       <= '0;
      con     <= 1'b0;
      inport  <= '0;
      outport <= '0;
    end else begin
      if (R_in)           regs[sel] <= bus;
      if (PC_enable)      pc <= IncPC ? pc + 32'd1 : bus;
      if (IR_enable)      ir <= bus;
      if (MAR_enable)     mar <= bus;
      if (MDR_enable)     mdr <= MDR_read ? Mdatain : bus;
      if (HI_enable)      hi <= bus;
      if (LO_enable)      lo <= bus;
      if (Y_enable)       y <= bus;
      if (ZHighIn)        z[63:32] <= alu_result[63:32];
      if (ZLowIn)         z[31:0] <= alu_result[31:0];
      if (CONin)          con <= con_next;
      if (OutPort_enable) outport <= bus;
      inport <= InPort_input;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed walk through fetch/addi/mflo/mul/div/BAout/CON,
// then randomized strobes against an arithmetic reference model.
module tb_datapath;
  logic Clock = 1'b0;
  logic Clear = 1'b0;
  logic [31:0] OutPort_output;
  logic IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
  logic Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable;
  logic OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, BAout;
  logic R_in, R_out, Cin;
  logic [31:0] InPort_input = '0;
  logic [31:0] Mdatain = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_in, m_out;
  logic [63:0] m_z;
  logic        m_con;

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .Clear(Clear), .OutPort_output(OutPort_output),
    .IncPC(IncPC), .CONin(CONin), .RAM_write(RAM_write), .MDR_enable(MDR_enable),
    .MDRout(MDRout), .MAR_enable(MAR_enable), .IR_enable(IR_enable), .MDR_read(MDR_read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Y_enable(Y_enable), .PC_enable(PC_enable),
    .OutPort_enable(OutPort_enable), .InPortout(InPortout), .PCout(PCout), .Yout(Yout),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout), .Cout(Cout),
    .BAout(BAout), .InPort_input(InPort_input), .Mdatain(Mdatain),
    .R_in(R_in), .R_out(R_out), .Cin(Cin)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
    {Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable} = '0;
    {OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, BAout} = '0;
    {R_in, R_out, Cin} = '0;
  endtask

  function automatic int m_sel();
    int s = 0;
    if (Gra) s |= int'(m_ir[26:23]);
    if (Grb) s |= int'(m_ir[22:19]);
    if (Grc) s |= int'(m_ir[18:15]);
    return s;
  endfunction

  function automatic logic [31:0] m_bus();
    int s = m_sel();
    int c = m_ir[18] ? int'(m_ir[18:0]) - (1 << 19) : int'(m_ir[18:0]);
    if (R_out)     return m_r[s];
    if (BAout)     return (s == 0) ? 32'd0 : m_r[s];
    if (HIout)     return m_hi;
    if (LOout)     return m_lo;
    if (ZHighout)  return m_z[63:32];
    if (ZLowout)   return m_z[31:0];
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (InPortout) return m_in;
    if (Cout)      return 32'(c);
    if (Yout)      return m_y;
    return 32'd0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b, input int op);
    longint sa = longint'(a);
    longint sb = longint'(b);
    longint q, r;
    int sh = int'(b[4:0]);
    logic [31:0] x = a;
    if (a[31]) sa -= 64'sd4294967296;
    if (b[31]) sb -= 64'sd4294967296;
    case (op)
      4:      return {32'd0, a - b};
      9, 12:  return {32'd0, a & b};
      10, 13: return {32'd0, a | b};
      5:      return {32'd0, a >> sh};
      6:      return {32'd0, a << sh};
      7: begin
        for (int i = 0; i < sh; i++) x = {x[0], x[31:1]};
        return {32'd0, x};
      end
      8: begin
        for (int i = 0; i < sh; i++) x = {x[30:0], x[31]};
        return {32'd0, x};
      end
      14:     return 64'(sa * sb);
      15: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      16:     return {32'd0, 32'd0 - b};
      17:     return {32'd0, ~b};
      default: return {32'd0, a + b};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_in, m_out} = '0;
    m_z = '0;
    m_con = 1'b0;
  endtask

  // Evaluate everything from pre-edge state, then commit.
  task automatic model_step();
    logic [31:0] b = m_bus();
    int s = m_sel();
    logic [63:0] al = m_alu(m_y, b, int'(m_ir[31:27]));
    logic cn;
    case (m_ir[20:19])
      2'd0:    cn = (b == 32'd0);
      2'd1:    cn = (b != 32'd0);
      2'd2:    cn = ($signed(b) > 0);
      default: cn = ($signed(b) < 0);
    endcase
    check("bus", 64'(dut.bus), 64'(b));
    check("alu", dut.alu_result, al);
    if (R_in)           m_r[s] = b;
    if (PC_enable)      m_pc = IncPC ? m_pc + 32'd1 : b;
    if (IR_enable)      m_ir = b;
    if (MAR_enable)     m_mar = b;
    if (MDR_enable)     m_mdr = MDR_read ? Mdatain : b;
    if (HI_enable)      m_hi = b;
    if (LO_enable)      m_lo = b;
    if (Y_enable)       m_y = b;
    if (ZHighIn)        m_z[63:32] = al[63:32];
    if (ZLowIn)         m_z[31:0] = al[31:0];
    if (CONin)          m_con = cn;
    if (OutPort_enable) m_out = b;
    m_in = InPort_input;
  endtask

  task automatic check_state();
    check("pc", 64'(dut.pc), 64'(m_pc));
    check("ir", 64'(dut.ir), 64'(m_ir));
    check("mar", 64'(dut.mar), 64'(m_mar));
    check("mdr", 64'(dut.mdr), 64'(m_mdr));
    check("hi", 64'(dut.hi), 64'(m_hi));
    check("lo", 64'(dut.lo), 64'(m_lo));
    check("y", 64'(dut.y), 64'(m_y));
    check("z", dut.z, m_z);
    check("con", 64'(dut.con), 64'(m_con));
    check("outport", 64'(OutPort_output), 64'(m_out));
    for (int i = 0; i < 16; i++) check($sformatf("r%0d", i), 64'(dut.regs[i]), 64'(m_r[i]));
  endtask

  task automatic tick();
    InPort_input = $urandom;
    #1;
    model_step();
    @(posedge Clock);
    #1;
    check_state();
    idle();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    #2;
    model_reset();
    check_state();
    check("out_clear", 64'(OutPort_output), 64'd0);
    Clear = 1'b0;
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v;
    MDR_read = 1'b1;
    MDR_enable = 1'b1;
    tick();
  endtask

  initial begin
    logic [25:0] v;
    idle();
    do_clear();

    IncPC = 1; PC_enable = 1; tick();
    check("pc_inc", 64'(dut.pc), 64'd1);
    PCout = 1; MAR_enable = 1; tick();
    check("mar_pc", 64'(dut.mar), 64'd1);
    mdr_load(32'h5908_0002);
    check("mdr_fetch", 64'(dut.mdr), 64'h5908_0002);
    MDRout = 1; IR_enable = 1; tick();
    check("ir_fetch", 64'(dut.ir), 64'h5908_0002);

    mdr_load(32'd5);
    MDRout = 1; Grb = 1; R_in = 1; tick();
    Grb = 1; R_out = 1; Y_enable = 1; tick();
    check("y_r1", 64'(dut.y), 64'd5);
    Cout = 1; ZLowIn = 1; tick();
    check("addi_zlo", 64'(dut.z[31:0]), 64'd7);
    ZLowout = 1; Gra = 1; R_in = 1; tick();
    check("addi_r2", 64'(dut.regs[2]), 64'd7);
    Gra = 1; R_out = 1; OutPort_enable = 1; tick();
    check("addi_out", 64'(OutPort_output), 64'd7);

    do_clear();
    check("clr_pc", 64'(dut.pc), 64'd0);
    check("clr_ir", 64'(dut.ir), 64'd0);

    mdr_load(32'h5908_0002);
    MDRout = 1; IR_enable = 1; tick();
    mdr_load(32'h0000_1234);
    MDRout = 1; LO_enable = 1; tick();
    LOout = 1; Gra = 1; R_in = 1; tick();
    check("mflo_r2", 64'(dut.regs[2]), 64'h1234);
    Gra = 1; R_out = 1; OutPort_enable = 1; tick();
    check("mflo_out", 64'(OutPort_output), 64'h1234);

    mdr_load(32'h7000_0000);
    MDRout = 1; IR_enable = 1; tick();
    mdr_load(32'hFFFF_FFFD);
    MDRout = 1; Y_enable = 1; tick();
    mdr_load(32'd4);
    MDRout = 1; ZHighIn = 1; ZLowIn = 1; tick();
    check("mul_z", dut.z, 64'hFFFF_FFFF_FFFF_FFF4);

    mdr_load(32'h7800_0000);
    MDRout = 1; IR_enable = 1; tick();
    mdr_load(32'd17);
    MDRout = 1; Y_enable = 1; tick();
    mdr_load(32'd5);
    MDRout = 1; ZHighIn = 1; ZLowIn = 1; tick();
    check("div_z", dut.z, {32'd2, 32'd3});
    ZHighout = 1; OutPort_enable = 1; tick();
    check("div_rem_out", 64'(OutPort_output), 64'd2);

    mdr_load(32'd0);
    MDRout = 1; IR_enable = 1; tick();
    mdr_load(32'd9);
    MDRout = 1; Gra = 1; R_in = 1; tick();
    check("r0_write", 64'(dut.regs[0]), 64'd9);
    BAout = 1; Gra = 1; OutPort_enable = 1; tick();
    check("baout_r0", 64'(OutPort_output), 64'd0);
    R_out = 1; Gra = 1; OutPort_enable = 1; tick();
    check("rout_r0", 64'(OutPort_output), 64'd9);

    mdr_load(32'h0018_0000);
    MDRout = 1; IR_enable = 1; tick();
    mdr_load(32'hFFFF_FFFF);
    MDRout = 1; CONin = 1; tick();
    check("con_neg", 64'(dut.con), 64'd1);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0) do_clear();
      v = 26'($urandom & $urandom & $urandom);
      {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, HI_enable,
       LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable, InPortout, PCout,
       Yout, ZLowout, ZHighout, LOout, HIout, Cout, BAout, R_in, R_out, Cin} = v;
      {Gra, Grb, Grc} = 3'($urandom);
      MDR_read = 1'($urandom);
      if ($urandom_range(0, 3) == 0) Mdatain = $urandom;
      else Mdatain = {5'($urandom_range(3, 17)), 27'($urandom)};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
